// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Producer-side handshake and line signals of the UART
//                transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output valid,
        input  ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  valid,
        output ready,
        output tx,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter; frames a word as start, LSB-first data,
//                stop, each bit lasting CLKS_PER_BIT clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic  clk,
    input  wire logic  reset,
    uart_tx_if.slave   bus
);
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bit_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [c_cnt_w-1:0] r_cnt, w_cnt;
    logic [c_bit_w-1:0] r_bit, w_bit;
    logic [WIDTH-1:0]   r_shift, w_shift;
    logic               r_tx, w_tx;
    logic               r_ready, w_ready;
    logic               r_busy, w_busy;
    logic               r_done, w_done;

    logic               w_cnt_wrap;
    logic [c_bit_w-1:0] w_bit_inc;

    assign w_cnt_wrap = (r_cnt == c_cnt_last);
    assign w_bit_inc  = r_bit + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Every output is computed one cycle ahead so the registered value lines
    // up with the state it belongs to.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_ready = r_ready;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.valid && r_ready) begin
                    w_state = S_START;
                    w_shift = bus.data_in;
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_tx    = 1'b0;
                    w_ready = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            S_START: begin
                if (w_cnt_wrap) begin
                    w_state = S_DATA;
                    w_cnt   = '0;
                    w_tx    = r_shift[0];
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_wrap) begin
                    w_cnt = '0;
                    if (r_bit == c_bit_last) begin
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit = w_bit_inc;
                        w_tx  = r_shift[w_bit_inc];
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_cnt_wrap) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_tx    = 1'b1;
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.tx    = r_tx;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Randomized scoreboard bench for uart_tx (C=4) plus a short
//                directed run of a single-clock-per-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    localparam int W     = 8;
    localparam int C     = 4;
    localparam int FRAME = C * (W + 2);

    typedef struct {
        logic [W-1:0] word;
        int           k;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_if #(.WIDTH(W)) bus  ();
    uart_tx_if #(.WIDTH(W)) bus1 ();

    uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    uart_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    exp_t         exp_q[$];
    int           cyc     = 0;
    int           n_total = 0;
    int           n_pass  = 0;
    logic [W-1:0] rx_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Line level for frame position pos (one position per serial bit).
    function automatic logic frame_bit(input logic [W-1:0] w, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= W) return w[pos-1];
        return 1'b1;
    endfunction

    // Monitor: samples just after each rising edge and compares with the
    // frame expected from the front of the scoreboard queue.
    always begin
        int   d;
        logic exp_busy, exp_done, exp_tx;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            check("reset_state", {28'd0, bus.tx, bus.ready, bus.busy, bus.done}, 32'b1100);
            exp_q.delete();
        end else begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_tx   = 1'b1;
            if (exp_q.size() > 0) begin
                d = cyc - exp_q[0].k;
                if (d >= 0 && d < FRAME) begin
                    exp_busy = 1'b1;
                    exp_tx   = frame_bit(exp_q[0].word, d / C);
                    if ((d % C) == C / 2 && d / C >= 1 && d / C <= W)
                        rx_word[d/C-1] = bus.tx;
                end else if (d == FRAME) begin
                    exp_done = 1'b1;
                end
            end
            check("line_tx", {31'd0, bus.tx}, {31'd0, exp_tx});
            check("status", {29'd0, bus.ready, bus.busy, bus.done},
                  {29'd0, ~exp_busy, exp_busy, exp_done});
            if (exp_done) begin
                check("rx_word", {24'd0, rx_word}, {24'd0, exp_q[0].word});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit hold, output int k);
        int guard;
        guard = 0;
        k     = -1;
        @(negedge clk);
        bus.data_in = w;
        bus.valid   = 1'b1;
        while (!bus.ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            k = cyc + 1;
            exp_q.push_back('{word: w, k: k});
            @(posedge clk);
            if (!hold) begin
                @(negedge clk);
                bus.valid   = 1'b0;
                bus.data_in = W'($urandom);
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || bus.busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k1, k2, gap;
        bus.data_in  = '0;
        bus.valid    = 1'b0;
        bus1.data_in = '0;
        bus1.valid   = 1'b0;

        // Reset, then idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Single frame
        send(8'hA5, 1'b0, k1);
        drain();

        // Back-to-back with valid held high
        send(8'h00, 1'b1, k1);
        send(8'hFF, 1'b0, k2);
        check("b2b_spacing", k2 - k1, FRAME + 1);
        drain();

        // New word offered mid-frame is ignored
        send(8'h0F, 1'b0, k1);
        repeat (3 * C) @(negedge clk);
        bus.data_in = 8'h3C;
        bus.valid   = 1'b1;
        @(negedge clk);
        bus.valid   = 1'b0;
        drain();

        // Reset during data bit 3, then a clean frame
        send(8'hC3, 1'b0, k1);
        repeat (4 * C + 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h81, 1'b0, k1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                bus.valid   = 1'b0;
                bus.data_in = W'($urandom);
            end
            send(W'($urandom), bit'($urandom_range(0, 1)), k1);
        end
        @(negedge clk);
        bus.valid = 1'b0;
        drain();

        // One clock per bit
        @(negedge clk);
        bus1.data_in = 8'h55;
        bus1.valid   = 1'b1;
        check("c1_ready", {31'd0, bus1.ready}, 32'd1);
        @(negedge clk);
        bus1.valid = 1'b0;
        for (int d = 0; d < W + 2; d++) begin
            check("c1_tx", {31'd0, bus1.tx}, {31'd0, frame_bit(8'h55, d)});
            check("c1_status", {29'd0, bus1.ready, bus1.busy, bus1.done}, 32'b010);
            @(negedge clk);
        end
        check("c1_done", {29'd0, bus1.ready, bus1.busy, bus1.done}, 32'b101);
        @(negedge clk);
        check("c1_done_clear", {31'd0, bus1.done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
